norm_lzd_shifter: RTL
=====================

Name: norm_lzd_shifter

Overview:
Post-adder normalization unit. Takes the registered sum, carry-out and operation flag from the add/subtract stage. It counts leading zeros and left-shifts the significand so the MSB is 1. On an effective-add carry-out it instead right-shifts by one. It reports the shift amount and direction to the exponent-adjust logic and hands back to the FPU control FSM with a start/done handshake.

Parameters:
SWR, 26, significand/result width in bits (MSB index SWR-1).
EWR, 5, width of shift-count output; 2^EWR >= SWR required.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start_i  input  1  FSM request; sampled only in IDLE
Add_Sub_i  input  1  effective operation of the sum: 0 = add, 1 = subtract
Data_i  input  SWR  registered adder result
Carry_i  input  1  adder carry-out
Data_o  output  SWR  normalized significand
Shift_o  output  EWR  shift magnitude applied
Right_o  output  1  1 = right shift by 1 (exponent +1), 0 = left shift (exponent -Shift_o)
Zero_o  output  1  result exactly zero
busy_o  output  1  high in any state except IDLE
done_o  output  1  one-cycle pulse; outputs valid from this cycle until next start

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; Data_o=0, Shift_o=0, Right_o=0, Zero_o=0, busy_o=0, done_o=0. Reset in any state aborts the operation with no done pulse.
- States: IDLE, COUNT, SHIFT, DONE.
- IDLE: on start_i=1, capture Data_i, Carry_i, Add_Sub_i into internal registers and go to COUNT. start_i in any other state is ignored; it is not queued.
- COUNT: evaluate in priority order.
  - Carry and Add_Sub=0: right-shift case. Right=1, count=1, go to SHIFT.
  - Captured data = 0: Zero_o=1, Shift_o=0, Data_o=0, Right_o=0, skip SHIFT, go to DONE.
  - Otherwise: count = number of leading zeros from bit SWR-1 (0..SWR-1), via priority encoder, registered. Right=0. Go to SHIFT.
- In subtract mode (Add_Sub=1) Carry is ignored; the input is already the magnitude.
- SHIFT:
  - Right case: Data_o = {1'b1, data[SWR-1:1]}.
  - Left case: Data_o = data << count, zero fill.
  - Shift_o=count, Zero_o=0. Go to DONE.
- DONE: done_o=1 for exactly this cycle, then IDLE. Data_o, Shift_o, Right_o and Zero_o hold until the next accepted start.
- Latency: start accepted at edge N, done_o high in the cycle after edge N+3 (zero case after edge N+2). Throughput: one operation per 4 cycles.
- Already normalized input (MSB=1, no carry): Shift_o=0, Data_o=Data_i, Right_o=0.
- start_i held high continuously: a new operation is accepted on the first IDLE cycle after DONE.

Optional Feature:
Macro NORM_STICKY_EN.
- Defined: in the right-shift case, Data_o[0] = data[1] | data[0], so the discarded bit is kept as sticky for rounding.
- Undefined: Data_o[0] = data[1]; the discarded bit is lost.
- Left shifts and all other outputs are identical in both builds.

Test Plan:
- Reset mid-operation: start with Data_i=26'h0000100, assert rst in the SHIFT state -> next cycle all outputs 0, busy_o=0, no done_o pulse.
- Left normalize: Data_i=26'h0000100, Carry_i=0, Add_Sub_i=1 -> done_o after 4 edges; Data_o=26'h2000000, Shift_o=17, Right_o=0, Zero_o=0.
- Carry right shift: Data_i=26'h0000001, Carry_i=1, Add_Sub_i=0.
  - NORM_STICKY_EN defined -> Data_o=26'h2000001, Shift_o=1, Right_o=1.
  - Undefined -> Data_o=26'h2000000, Shift_o=1, Right_o=1.
- Zero result: Data_i=0, Carry_i=1, Add_Sub_i=1 -> Zero_o=1, Data_o=0, Shift_o=0, done_o after 3 edges.
- Already normalized plus busy-ignore: Data_i=26'h3FFFFFF, then pulse start_i again in COUNT -> Data_o=26'h3FFFFFF, Shift_o=0, exactly one done_o pulse.
- Max shift: Data_i=26'h0000001, Add_Sub_i=1 -> Shift_o=25, Data_o=26'h2000000.

Source files
------------

// File: rtl/norm_lzd_shifter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// norm_lzd_shifter
//   Post-adder normalization for the FPU datapath. It takes the registered
//   adder sum and either:
//     - right-shifts it by one when an effective add produced a carry-out, or
//     - counts its leading zeros and left-shifts it until the MSB is 1.
//   The exponent-adjust logic receives the shift amount and direction. The FPU
//   control FSM drives this unit through a start/done handshake.
//
// Optional build macro: NORM_STICKY_EN
//   When it is defined, the right-shift case ORs the discarded LSB into
//   Data_o[0] so that rounding still sees it as sticky. When it is undefined,
//   that bit is dropped.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start_i    request from the FPU FSM, sampled only while idle
//   Add_Sub_i  effective operation: 0 = add, 1 = subtract
//   Data_i     [SWR-1:0] adder result
//   Carry_i    adder carry-out
//   Data_o     [SWR-1:0] normalized significand
//   Shift_o    [EWR-1:0] applied shift magnitude
//   Right_o    1 = right shift by one (exp+1), 0 = left shift (exp-Shift_o)
//   Zero_o     result is exactly zero
//   busy_o     high whenever not idle
//   done_o     one-cycle pulse; results stay valid until the next start
//
// Sequence: IDLE -> COUNT -> SHIFT -> DONE -> IDLE. A zero result skips SHIFT.
// All outputs are registered. done_o rises on the edge that leaves DONE, so
// the pulse appears three edges after the accepting edge (two for a zero
// result). A new start is taken in that same IDLE cycle, which gives one
// operation every four cycles.
// EWR must satisfy 2**EWR >= SWR so that a count of SWR-1 fits.
// -----------------------------------------------------------------------------
module norm_lzd_shifter #(
  parameter int SWR = 26,
  parameter int EWR = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           Add_Sub_i,
  input  logic [SWR-1:0] Data_i,
  input  logic           Carry_i,
  output logic [SWR-1:0] Data_o,
  output logic [EWR-1:0] Shift_o,
  output logic           Right_o,
  output logic           Zero_o,
  output logic           busy_o,
  output logic           done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;

  // Operands captured at start
  logic [SWR-1:0] data_q, data_d;
  logic           carry_q, carry_d;
  logic           sub_q, sub_d;

  // Decision made in COUNT and consumed in SHIFT
  logic           rgt_q, rgt_d;
  logic [EWR-1:0] cnt_q, cnt_d;

  // Registered outputs
  logic [SWR-1:0] dout_q, dout_d;
  logic [EWR-1:0] shift_q, shift_d;
  logic           right_q, right_d;
  logic           zero_q, zero_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // Leading-zero count. The scan runs from the MSB down, and the first set
  // bit wins. An all-zero value leaves lzc at 0, but the zero case is
  // intercepted in COUNT before lzc is used.
  logic [EWR-1:0] lzc;
  logic           lz_found;

  always_comb begin
    lzc      = '0;
    lz_found = 1'b0;
    for (int i = SWR-1; i >= 0; i--) begin
      if (!lz_found && data_q[i]) begin
        lzc      = EWR'(SWR-1-i);
        lz_found = 1'b1;
      end
    end
  end

  // Shift datapaths. The right shift re-inserts the carry-out as the new MSB.
  logic [SWR-1:0] rsh_data;
  logic [SWR-1:0] lsh_data;

  always_comb begin
    rsh_data = {1'b1, data_q[SWR-1:1]};
`ifdef NORM_STICKY_EN
    rsh_data[0] = data_q[1] | data_q[0];
`else
    rsh_data[0] = data_q[1];
`endif
    lsh_data = data_q << cnt_q;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    rgt_d   = rgt_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    shift_d = shift_q;
    right_d = right_q;
    zero_d  = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          data_d  = Data_i;
          carry_d = Carry_i;
          sub_d   = Add_Sub_i;
          state_d = S_COUNT;
        end
      end

      S_COUNT: begin
        // Carry matters only for an effective add. A subtract result is
        // already a magnitude.
        if (carry_q && !sub_q) begin
          rgt_d   = 1'b1;
          cnt_d   = EWR'(1);
          state_d = S_SHIFT;
        end else if (data_q == '0) begin
          zero_d  = 1'b1;
          shift_d = '0;
          dout_d  = '0;
          right_d = 1'b0;
          state_d = S_DONE;
        end else begin
          rgt_d   = 1'b0;
          cnt_d   = lzc;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        dout_d  = rgt_q ? rsh_data : lsh_data;
        shift_d = cnt_q;
        right_d = rgt_q;
        zero_d  = 1'b0;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // done_o pulses as the unit leaves DONE. busy_o tracks the state being
    // entered, so it is low exactly in IDLE.
    done_d = (state_q == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      rgt_q   <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= '0;
      shift_q <= '0;
      right_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      rgt_q   <= rgt_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      shift_q <= shift_d;
      right_q <= right_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Data_o  = dout_q;
  assign Shift_o = shift_q;
  assign Right_o = right_q;
  assign Zero_o  = zero_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
